// File: rtl/execute_cycle.sv
// EX stage of the 5-stage RV32I pipeline: forwarding muxes, ALU, branch/JAL resolution and EX/MEM register.
// Optional 2-cycle MUL unit enabled by defining EXECUTE_MUL_EN (default build: MulE ignored, MulBusyE = 0).
module execute_cycle (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteE,
    input  logic [1:0]  ResultSrcE,
    input  logic        MemWriteE,
    input  logic        JumpE,
    input  logic        BranchE,
    input  logic [2:0]  Funct3E,
    input  logic [2:0]  ALUControlE,
    input  logic        ALUSrcE,
    input  logic        MulE,
    input  logic [31:0] RD1_E,
    input  logic [31:0] RD2_E,
    input  logic [31:0] Imm_Ext_E,
    input  logic [4:0]  RD_E,
    input  logic [31:0] PCE,
    input  logic [31:0] PCPlus4E,
    input  logic [1:0]  ForwardA_E,
    input  logic [1:0]  ForwardB_E,
    input  logic [31:0] ResultW,
    output logic        PCSrcE,
    output logic [31:0] PCTargetE,
    output logic        MulBusyE,
    output logic        RegWriteM,
    output logic        MemWriteM,
    output logic [1:0]  ResultSrcM,
    output logic [4:0]  RD_M,
    output logic [31:0] ALUResultM,
    output logic [31:0] WriteDataM,
    output logic [31:0] PCPlus4M,
    output logic        o_dbg_mul_state
);

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SLT  = 3'b101;
    localparam logic [2:0] ALU_SLTU = 3'b110;
    localparam logic [2:0] ALU_SLL  = 3'b111;

    localparam logic [2:0] BR_EQ  = 3'b000;
    localparam logic [2:0] BR_NE  = 3'b001;
    localparam logic [2:0] BR_LT  = 3'b100;
    localparam logic [2:0] BR_GE  = 3'b101;
    localparam logic [2:0] BR_LTU = 3'b110;
    localparam logic [2:0] BR_GEU = 3'b111;

    logic [31:0] w_src_a;
    logic [31:0] w_fwd_b;
    logic [31:0] w_src_b;
    logic [31:0] w_alu_result;
    logic [31:0] w_ex_result;
    logic        w_bubble;
    logic        w_eq;
    logic        w_lt;
    logic        w_ltu;
    logic        w_branch_cond;

    // Forwarding: 01 = WB result, 10 = our own EX/MEM result, 00/11 = register file value.
    always_comb begin
        case (ForwardA_E)
            2'b01:   w_src_a = ResultW;
            2'b10:   w_src_a = ALUResultM;
            default: w_src_a = RD1_E;
        endcase
    end

    always_comb begin
        case (ForwardB_E)
            2'b01:   w_fwd_b = ResultW;
            2'b10:   w_fwd_b = ALUResultM;
            default: w_fwd_b = RD2_E;
        endcase
    end

    assign w_src_b = ALUSrcE ? Imm_Ext_E : w_fwd_b;

    always_comb begin
        case (ALUControlE)
            ALU_ADD:  w_alu_result = w_src_a + w_src_b;
            ALU_SUB:  w_alu_result = w_src_a - w_src_b;
            ALU_AND:  w_alu_result = w_src_a & w_src_b;
            ALU_OR:   w_alu_result = w_src_a | w_src_b;
            ALU_XOR:  w_alu_result = w_src_a ^ w_src_b;
            ALU_SLT:  w_alu_result = {31'd0, ($signed(w_src_a) < $signed(w_src_b))};
            ALU_SLTU: w_alu_result = {31'd0, (w_src_a < w_src_b)};
            ALU_SLL:  w_alu_result = w_src_a << w_src_b[4:0];
            default:  w_alu_result = 32'd0;
        endcase
    end

    // Branch compare always uses forwarded register operands, never the immediate.
    assign w_eq  = (w_src_a == w_fwd_b);
    assign w_lt  = ($signed(w_src_a) < $signed(w_fwd_b));
    assign w_ltu = (w_src_a < w_fwd_b);

    always_comb begin
        case (Funct3E)
            BR_EQ:   w_branch_cond = w_eq;
            BR_NE:   w_branch_cond = ~w_eq;
            BR_LT:   w_branch_cond = w_lt;
            BR_GE:   w_branch_cond = ~w_lt;
            BR_LTU:  w_branch_cond = w_ltu;
            BR_GEU:  w_branch_cond = ~w_ltu;
            default: w_branch_cond = 1'b0;
        endcase
    end

    assign PCSrcE    = JumpE | (BranchE & w_branch_cond);
    assign PCTargetE = PCE + Imm_Ext_E;

`ifdef EXECUTE_MUL_EN
    // Stall contract: while MulBusyE is high the hazard unit holds the IF/ID/EX inputs
    // unchanged, so the MUL_WAIT cycle sees the same instruction that launched the multiply.
    typedef enum logic {
        S_IDLE     = 1'b0,
        S_MUL_WAIT = 1'b1
    } mul_state_t;

    mul_state_t  r_state;
    mul_state_t  w_state_next;
    logic [31:0] r_mul_prod;
    logic [31:0] w_mul_prod;
    logic        w_mul_launch;
    logic        w_mul_done;

    assign w_mul_prod = w_src_a * w_src_b;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:     if (MulE) w_state_next = S_MUL_WAIT;
            S_MUL_WAIT: w_state_next = S_IDLE;
            default:    w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_mul_launch = 1'b0;
        w_mul_done   = 1'b0;
        MulBusyE     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_mul_launch = MulE;
                MulBusyE     = MulE;
            end
            S_MUL_WAIT: w_mul_done = 1'b1;
            default: begin
                w_mul_launch = 1'b0;
                w_mul_done   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mul_prod <= 32'd0;
        end else if (w_mul_launch) begin
            r_mul_prod <= w_mul_prod;
        end
    end

    assign w_bubble        = w_mul_launch;
    assign w_ex_result     = w_mul_done ? r_mul_prod : w_alu_result;
    assign o_dbg_mul_state = (r_state == S_MUL_WAIT);
`else
    logic w_unused_mul;

    assign w_unused_mul    = MulE;
    assign w_bubble        = 1'b0;
    assign w_ex_result     = w_alu_result;
    assign MulBusyE        = 1'b0;
    assign o_dbg_mul_state = 1'b0;
`endif

    // EX/MEM register; a launching multiply pushes a bubble into MEM for one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            ResultSrcM <= 2'b00;
            RD_M       <= 5'd0;
            ALUResultM <= 32'd0;
            WriteDataM <= 32'd0;
            PCPlus4M   <= 32'd0;
        end else if (w_bubble) begin
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            ResultSrcM <= 2'b00;
            RD_M       <= 5'd0;
            ALUResultM <= 32'd0;
            WriteDataM <= 32'd0;
            PCPlus4M   <= 32'd0;
        end else begin
            RegWriteM  <= RegWriteE;
            MemWriteM  <= MemWriteE;
            ResultSrcM <= ResultSrcE;
            RD_M       <= RD_E;
            ALUResultM <= w_ex_result;
            WriteDataM <= w_fwd_b;
            PCPlus4M   <= PCPlus4E;
        end
    end

endmodule
